// File: rtl/piano_pkg.sv
// -----------------------------------------------------------------------------
// piano_pkg
//   Definitions shared by the piano / ear-training blocks:
//     - BASE_CLKS_PER_PERIOD : CLK100MHZ clocks per period of the lowest octave
//                              C..B (index 0 = C, index 11 = B). Each higher
//                              octave is a right shift of this table.
//     - NUM_KEYS_PER_OCT     : keys per octave (12)
//     - MAX_CHORD_NOTES      : notes in one ear-training chord (3)
//     - arp_state_t          : state encoding of arp_sequencer
//   No ports (package).
// -----------------------------------------------------------------------------
package piano_pkg;

    localparam int NUM_KEYS_PER_OCT = 12;
    localparam int MAX_CHORD_NOTES  = 3;

    localparam logic [31:0] BASE_CLKS_PER_PERIOD [NUM_KEYS_PER_OCT] = '{
        32'd3057805,  // C
        32'd2886186,  // C#
        32'd2724195,  // D
        32'd2571296,  // D#
        32'd2426984,  // E
        32'd2290767,  // F
        32'd2162195,  // F#
        32'd2040841,  // G
        32'd1926296,  // G#
        32'd1818182,  // A
        32'd1716134,  // A#
        32'd1619816   // B
    };

    typedef enum logic [2:0] {
        ARP_IDLE,
        ARP_LOAD,
        ARP_PLAY,
        ARP_GAP,
        ARP_DONE
    } arp_state_t;

endpackage

// File: rtl/note_period_lut.sv
// -----------------------------------------------------------------------------
// note_period_lut
//   Combinational note-id to tone-period lookup, shared by the arpeggio
//   sequencer and the ear-training single-note path.
//   octid = id - RANGE_OFFSET (7-bit wrap); octid 1..12 selects C..B of the
//   base table, shifted right by OCT_SHIFT to reach the playback octave.
//   Ports:
//     id     in  7   note id
//     period out 32  clocks per tone period (0 when invalid)
//     valid  out 1   id maps to a key in the supported range
// -----------------------------------------------------------------------------
module note_period_lut #(
    parameter int RANGE_OFFSET = 27,
    parameter int OCT_SHIFT    = 3
) (
    input  logic [6:0]  id,
    output logic [31:0] period,
    output logic        valid
);
    import piano_pkg::*;

    logic [6:0] octid;
    logic [3:0] key;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise paths that skip an assignment infer a latch.
        period = '0;
        valid  = 1'b0;
        octid  = id - 7'(RANGE_OFFSET);
        key    = octid[3:0] - 4'd1;
        // An id below the offset wraps to a large octid and lands here as invalid.
        if ((octid >= 7'd1) && (octid <= 7'(NUM_KEYS_PER_OCT))) begin
            valid  = 1'b1;
            period = BASE_CLKS_PER_PERIOD[key] >> OCT_SHIFT;
        end
    end

endmodule

// File: rtl/arp_sequencer.sv
// -----------------------------------------------------------------------------
// arp_sequencer
//   Ear-training playback controller. A start pulse latches up to three note
//   ids and plays them one at a time through a single freq_pwm tone generator:
//   each note sounds for NOTE_CYCLES clocks followed by GAP_CYCLES of silence.
//   Ids outside the supported range are skipped without a load strobe.
//
//   Optional feature (macro ARP_LOOP_EN): adds input loop_en; when high at the
//   end of the last note's gap, the sequence restarts from note 0 with no done.
//
//   Ports:
//     CLK100MHZ        in  1   system clock
//     CPU_RESETN       in  1   asynchronous active-low reset
//     start            in  1   one-cycle request to play (ignored while busy)
//     abort            in  1   return to idle on the next edge, no done
//     note_num         in  2   notes to play, 0..3
//     note_id_0..2     in  7   note ids, played in index order
//     loop_en          in  1   (ARP_LOOP_EN only) repeat the sequence
//     clks_per_period  out 32  period for freq_pwm, holds its last value
//     new_period       out 1   one-cycle load strobe for freq_pwm
//     note_active      out 1   gate for eartraining_pwm / eartraining_sd
//     busy             out 1   sequence in progress (LOAD/PLAY/GAP/DONE)
//     done             out 1   one-cycle completion pulse
//     cur_idx          out 2   index of the note being handled
// -----------------------------------------------------------------------------
module arp_sequencer #(
    parameter int NOTE_CYCLES  = 50_000_000,
    parameter int GAP_CYCLES   = 5_000_000,
    parameter int RANGE_OFFSET = 27,
    parameter int OCT_SHIFT    = 3
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  note_num,
    input  logic [6:0]  note_id_0,
    input  logic [6:0]  note_id_1,
    input  logic [6:0]  note_id_2,
`ifdef ARP_LOOP_EN
    input  logic        loop_en,
`endif
    output logic [31:0] clks_per_period,
    output logic        new_period,
    output logic        note_active,
    output logic        busy,
    output logic        done,
    output logic [1:0]  cur_idx
);
    import piano_pkg::*;

    localparam int CNT_MAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    arp_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       num_q;
    logic [6:0]       id_q [MAX_CHORD_NOTES];

    logic [6:0]       cur_id;
    logic [31:0]      lut_period;
    logic             lut_valid;
    logic             more_notes;
    logic             loop_now;

`ifdef ARP_LOOP_EN
    assign loop_now = loop_en;
`else
    assign loop_now = 1'b0;
`endif

    always_comb begin
        case (cur_idx)
            2'd1:    cur_id = id_q[1];
            2'd2:    cur_id = id_q[2];
            default: cur_id = id_q[0];
        endcase
    end

    // Widened to 3 bits so that cur_idx+1 cannot wrap before the compare.
    assign more_notes = (3'(cur_idx) + 3'd1) < 3'(num_q);

    note_period_lut #(
        .RANGE_OFFSET (RANGE_OFFSET),
        .OCT_SHIFT    (OCT_SHIFT)
    ) u_lut (
        .id     (cur_id),
        .period (lut_period),
        .valid  (lut_valid)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state           <= ARP_IDLE;
            cnt             <= '0;
            num_q           <= '0;
            // NOTE: the latched-id array is tiny, so it is reset like any other
            // register; large storage arrays would be left unreset.
            for (int i = 0; i < MAX_CHORD_NOTES; i++) id_q[i] <= '0;
            clks_per_period <= '0;
            new_period      <= 1'b0;
            note_active     <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            cur_idx         <= '0;
        end else begin
            new_period <= 1'b0;
            done       <= 1'b0;

            if (abort) begin
                state       <= ARP_IDLE;
                cnt         <= '0;
                note_active <= 1'b0;
                busy        <= 1'b0;
                cur_idx     <= '0;
            end else begin
                case (state)
                    ARP_IDLE: begin
                        if (start) begin
                            num_q   <= note_num;
                            id_q[0] <= note_id_0;
                            id_q[1] <= note_id_1;
                            id_q[2] <= note_id_2;
                            cur_idx <= '0;
                            cnt     <= '0;
                            busy    <= 1'b1;
                            if (note_num == 2'd0) begin
                                state <= ARP_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= ARP_LOAD;
                            end
                        end
                    end

                    ARP_LOAD: begin
                        cnt <= '0;
                        if (lut_valid) begin
                            // Period and strobe land together on the first PLAY cycle.
                            clks_per_period <= lut_period;
                            new_period      <= 1'b1;
                            note_active     <= 1'b1;
                            state           <= ARP_PLAY;
                        end else if (more_notes) begin
                            cur_idx <= cur_idx + 2'd1;
                        end else if (loop_now) begin
                            cur_idx <= '0;
                        end else begin
                            state <= ARP_DONE;
                            done  <= 1'b1;
                        end
                    end

                    ARP_PLAY: begin
                        if (cnt == NOTE_LAST) begin
                            cnt         <= '0;
                            note_active <= 1'b0;
                            state       <= ARP_GAP;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    ARP_GAP: begin
                        if (cnt == GAP_LAST) begin
                            cnt <= '0;
                            if (more_notes) begin
                                cur_idx <= cur_idx + 2'd1;
                                state   <= ARP_LOAD;
                            end else if (loop_now) begin
                                cur_idx <= '0;
                                state   <= ARP_LOAD;
                            end else begin
                                state <= ARP_DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    ARP_DONE: begin
                        state   <= ARP_IDLE;
                        cnt     <= '0;
                        busy    <= 1'b0;
                        cur_idx <= '0;
                    end

                    default: begin
                        state       <= ARP_IDLE;
                        cnt         <= '0;
                        note_active <= 1'b0;
                        busy        <= 1'b0;
                        cur_idx     <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/arp_sequencer.md
Name: arp_sequencer

Overview:
Ear-training playback controller. On a start pulse it sequences up to 3 MicroBlaze-supplied chord notes through one shared freq_pwm tone generator, one note at a time (arpeggio), with a timed gap between notes. It replaces the direct play_en-to-note-0 connection in the ear-training path: it drives freq_pwm's period and new_period inputs and the ear-training AUD_SD/PWM gate.

Parameters:
NOTE_CYCLES, 50_000_000, clocks each note sounds (0.5 s at 100 MHz); must be >= 1
GAP_CYCLES, 5_000_000, silent clocks after each note; must be >= 1
RANGE_OFFSET, 27, subtracted from note id to get the octave id (C3 = 28 -> 1)
OCT_SHIFT, 3, right-shift applied to the base C..B period table

Ports:
CLK100MHZ  in  1  system clock
CPU_RESETN  in  1  asynchronous active-low reset
start  in  1  one-cycle request to play the sequence
abort  in  1  stop immediately, no done
note_num  in  2  notes to play, 0..3 (3 = all)
note_id_0  in  7  first note id
note_id_1  in  7  second note id
note_id_2  in  7  third note id
clks_per_period  out  32  period to freq_pwm
new_period  out  1  one-cycle load strobe to freq_pwm
note_active  out  1  gate for eartraining_pwm / eartraining_sd
busy  out  1  sequence in progress
done  out  1  one-cycle completion pulse
cur_idx  out  2  index of the note being handled

Behaviour:
- Reset (async assert, sync deassert use): state IDLE; clks_per_period=0, new_period=0, note_active=0, busy=0, done=0, cur_idx=0, counters 0.
- States: IDLE, LOAD, PLAY, GAP, DONE.
- IDLE: start=1 at cycle t latches note_num and all three ids. Next state is LOAD at t+1. A note_num of 0 goes to DONE instead.
- LOAD: computes octid = id[cur_idx] - RANGE_OFFSET (7-bit subtract).
  - Valid octid is 1..12: clks_per_period = BASE[octid] >> OCT_SHIFT; next state PLAY.
  - Invalid octid (id outside 28..39): note skipped, no strobe; advance as at the end of GAP.
- PLAY: on the first PLAY cycle, new_period=1 for exactly that cycle and clks_per_period is already valid. note_active=1 for exactly NOTE_CYCLES cycles, then GAP.
- GAP: note_active=0 for GAP_CYCLES cycles. Then either cur_idx+1 < latched num gives cur_idx++ and LOAD, or else DONE.
- DONE: done=1 for one cycle, then IDLE with cur_idx=0.
- busy=1 in LOAD, PLAY, GAP and DONE.
- clks_per_period holds its last value after PLAY and in IDLE; it is cleared only by reset.
- start while busy is ignored (no re-latch). Input changes mid-sequence have no effect.
- abort has priority over all transitions. Any state returns to IDLE on the next edge with note_active=0, no done, cur_idx=0. abort and start together in IDLE: abort wins.
- Counters are $clog2(max(NOTE_CYCLES,GAP_CYCLES))+1 bits wide, reset to 0 on every state entry, and do not wrap.
- Reset mid-sequence: all outputs return to their reset values immediately (asynchronous).

Optional Feature:
ARP_LOOP_EN
- Defined: adds input port loop_en (1 bit). At the end of the final GAP, loop_en=1 gives cur_idx=0 and LOAD with no done; loop_en=0 gives DONE. abort still exits.
- Undefined: no loop_en port; single pass only.

Decomposition:
- Shared package piano_pkg holds:
  - the 12-entry BASE_CLKS_PER_PERIOD table (C=3057805 ... B=1619816)
  - NUM_KEYS_PER_OCT=12 and MAX_CHORD_NOTES=3
  - the arp state encoding
- Sub-module note_period_lut, combinational: input id[6:0]; outputs period[31:0] and valid. The ear-training path's single-note lookup reuses it.

Test Plan (NOTE_CYCLES=8, GAP_CYCLES=2):
- note_num=3, ids 28/37/39, start pulse → three new_period strobes with clks_per_period 382225, 227272 and 202477 in turn. Each strobe is followed by exactly 8 cycles of note_active=1 then 2 cycles low. done pulses once, with busy high throughout the sequence.
- note_num=0, start → no new_period, note_active stays 0; done is high 1 cycle after the start cycle (busy high that cycle).
- note_num=2, ids 28/5 (invalid) → one strobe (382225), 8 active cycles, then done with no second strobe.
- abort during the 4th PLAY cycle of note 1 → note_active low and busy low the next cycle, done never asserts, cur_idx=0. A subsequent start replays from note 0.
- start re-pulsed during GAP, and note_id_1 changed mid-PLAY → no effect; original sequence completes with the latched values.
- CPU_RESETN asserted asynchronously mid-PLAY → all outputs 0 immediately, before the next clock edge. ARP_LOOP_EN build with loop_en=1 → sequence repeats with no done until loop_en=0.
